uart_frame_checker: RTL

- Parametrised, synthesizable successor to the UART net protocol checker. It passively monitors one UART line.
- Frame format comes from configuration ports rather than APB snooping: 5..DATA_MAX data bits, optional even/odd parity, 1 or 2 stop bits, OSR-based baud divider.
- Decodes each frame and flags start, parity, stop, edge-timing and break conditions per frame. Keeps saturating frame and error counters.
- One instance sits on each UART TX/RX net in the testbench and in emulation builds.

---
 rtl/uart_frame_checker.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_checker.sv
// Passive UART line monitor: decodes frames per the cfg_* ports and reports
// start, parity, stop, edge-timing and break conditions plus saturating counters.
module uart_frame_checker #(
  parameter int OSR      = 16,
  parameter int DIV_W    = 8,
  parameter int DATA_MAX = 9,
  parameter int TOL      = 1,
  parameter int CNT_W    = 16
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                chk_en,
  input  logic [3:0]          cfg_data_bits,
  input  logic                cfg_parity_en,
  input  logic                cfg_parity_odd,
  input  logic                cfg_stop2,
  input  logic [DIV_W-1:0]    cfg_baud_div,
  input  logic                cnt_clr,
  input  logic                uart_net,
  output logic                frame_done,
  output logic [DATA_MAX-1:0] frame_data,
  output logic                err_start,
  output logic                err_parity,
  output logic                err_stop,
  output logic                err_timing,
  output logic                break_det,
  output logic [CNT_W-1:0]    frame_cnt,
  output logic [CNT_W-1:0]    err_cnt
);

  localparam int LOG2OSR = $clog2(OSR);
  localparam int CW      = LOG2OSR + DIV_W;
  localparam logic [3:0] DMAX4 = 4'(DATA_MAX);
  localparam logic [CW:0] TOL_X = (CW+1)'(TOL);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
  state_t state, state_nxt;

  logic s1, s2, s3;
  logic fall, line_edge;

  logic [3:0]          nd_cfg;
  logic [3:0]          lat_nd;
  logic                lat_par_en, lat_par_odd, lat_stop2;
  logic [DIV_W-1:0]    lat_div;

  logic [CW-1:0]       cnt, bw_m1, half;
  logic [CW:0]         cnt_x;
  logic                mid, wrap, last_bit, edge_ok, timed_state, sample;
  logic                start_fail, frame_end, final_brk, tim_now;

  logic [3:0]          bit_idx;
  logic [DATA_MAX-1:0] shreg;
  logic                par_acc, all_zero, tflag, par_err, stop_err, brk_wait;
  logic                any_err;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= uart_net;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign fall      = s3 & ~s2;
  assign line_edge = s3 ^ s2;

  always_comb begin
    nd_cfg = cfg_data_bits;
    if (cfg_data_bits < 4'd5)
      nd_cfg = 4'd5;
    else if (cfg_data_bits > DMAX4)
      nd_cfg = DMAX4;
  end

  // Bit period is OSR*(div+1); both derived values fit in CW bits.
  assign bw_m1 = {lat_div, {LOG2OSR{1'b1}}};
  assign half  = {1'b0, lat_div, {(LOG2OSR-1){1'b0}}} + CW'(OSR/2);
  assign cnt_x = {1'b0, cnt};

  assign mid         = (cnt == half);
  assign wrap        = (cnt == bw_m1);
  assign last_bit    = (bit_idx == lat_nd - 4'd1);
  assign edge_ok     = (cnt_x <= TOL_X) || ((cnt_x + TOL_X) >= {1'b0, bw_m1});
  assign timed_state = (state == DATA) || (state == PARITY) ||
                       (state == STOP1) || (state == STOP2);
  assign sample      = (state != IDLE) && mid;
  assign tim_now     = timed_state && line_edge && !edge_ok;
  assign start_fail  = chk_en && (state == START) && mid && s2;
  assign frame_end   = chk_en && mid &&
                       (((state == STOP1) && !lat_stop2) || (state == STOP2));
  assign final_brk   = all_zero & ~s2;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (fall && !brk_wait) state_nxt = START;
      START:  if (mid && s2) state_nxt = IDLE;
              else if (wrap) state_nxt = DATA;
      DATA:   if (wrap && last_bit) state_nxt = lat_par_en ? PARITY : STOP1;
      PARITY: if (wrap) state_nxt = STOP1;
      STOP1:  if (mid && !lat_stop2) state_nxt = IDLE;
              else if (wrap) state_nxt = STOP2;
      STOP2:  if (mid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!chk_en)
      state_nxt = IDLE;
  end

  // The fall cycle is cnt 0, so the first START cycle already holds 1.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      par_acc     <= 1'b0;
      all_zero    <= 1'b0;
      tflag       <= 1'b0;
      par_err     <= 1'b0;
      stop_err    <= 1'b0;
      brk_wait    <= 1'b0;
      lat_nd      <= 4'd5;
      lat_par_en  <= 1'b0;
      lat_par_odd <= 1'b0;
      lat_stop2   <= 1'b0;
      lat_div     <= '0;
      frame_done  <= 1'b0;
      frame_data  <= '0;
      err_start   <= 1'b0;
      err_parity  <= 1'b0;
      err_stop    <= 1'b0;
      err_timing  <= 1'b0;
      break_det   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      err_start  <= 1'b0;
      err_parity <= 1'b0;
      err_stop   <= 1'b0;
      err_timing <= 1'b0;
      break_det  <= 1'b0;

      if (state_nxt == IDLE)
        cnt <= '0;
      else if (state == IDLE)
        cnt <= CW'(1);
      else if (wrap)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      if (tim_now)
        tflag <= 1'b1;
      if (sample)
        all_zero <= all_zero & ~s2;

      case (state)
        IDLE: begin
          if (s2)
            brk_wait <= 1'b0;
          if (state_nxt == START) begin
            lat_nd      <= nd_cfg;
            lat_par_en  <= cfg_parity_en;
            lat_par_odd <= cfg_parity_odd;
            lat_stop2   <= cfg_stop2;
            lat_div     <= cfg_baud_div;
            bit_idx     <= '0;
            shreg       <= '0;
            par_acc     <= 1'b0;
            all_zero    <= 1'b1;
            tflag       <= 1'b0;
            par_err     <= 1'b0;
            stop_err    <= 1'b0;
          end
        end
        DATA: begin
          if (mid) begin
            shreg[bit_idx] <= s2;
            par_acc        <= par_acc ^ s2;
          end
          if (wrap)
            bit_idx <= bit_idx + 4'd1;
        end
        PARITY: if (mid) par_err <= s2 ^ par_acc ^ lat_par_odd;
        STOP1, STOP2: if (mid && !s2) stop_err <= 1'b1;
        default: ;
      endcase

      if (start_fail)
        err_start <= 1'b1;

      // A break masks the stop/parity errors it necessarily causes.
      if (frame_end) begin
        frame_done <= 1'b1;
        frame_data <= shreg;
        break_det  <= final_brk;
        err_stop   <= (stop_err | ~s2) & ~final_brk;
        err_parity <= par_err & ~final_brk;
        err_timing <= tflag | tim_now;
        if (final_brk)
          brk_wait <= 1'b1;
      end
    end
  end

  assign any_err = err_parity | err_stop | err_timing | break_det;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else if (cnt_clr) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (frame_done && (frame_cnt != {CNT_W{1'b1}}))
        frame_cnt <= frame_cnt + 1'b1;
      if ((err_start || (frame_done && any_err)) && (err_cnt != {CNT_W{1'b1}}))
        err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
